// File: rtl/pc_sequencer.sv
// Next-PC controller: chooses increment / absolute load / hold for the PC each cycle.
// It also owns the IDLE/RUN/HALT state and a return-address stack for call and return.
module pc_sequencer #(
    parameter int D     = 12,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stall,
    input  logic                         halt_req,
    input  logic                         jmp_en,
    input  logic                         br_en,
    input  logic                         br_flag,
    input  logic                         call_en,
    input  logic                         ret_en,
    input  logic [D-1:0]                 target,
    input  logic [D-1:0]                 curr_pc,
    output logic                         pc_absjump,
    output logic [D-1:0]                 pc_target,
    output logic                         running,
    output logic                         halted,
    output logic                         err_overflow,
    output logic                         err_underflow,
    output logic [$clog2(DEPTH+1)-1:0]   sp
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    typedef enum logic [3:0] {
        OP_HOLD, OP_HALT, OP_STALL, OP_UNDER, OP_RET,
        OP_OVER, OP_CALL, OP_JUMP, OP_NEXT
    } op_t;

    state_t         state_reg, state_next;
    logic [SPW-1:0] sp_reg, sp_next;
    logic           ovf_reg, ovf_next;
    logic           unf_reg, unf_next;
    logic           push;
    op_t            op;
    logic [D-1:0]   stack [0:DEPTH-1];
    logic [D-1:0]   ret_addr;

    assign ret_addr = stack[AW'(sp_reg - SPW'(1))];

    // Priority decode of the current cycle's operation; only RUN looks at the inputs.
    always_comb begin
        op = OP_HOLD;
        if (state_reg == RUN) begin
            if (halt_req)                           op = OP_HALT;
            else if (stall)                         op = OP_STALL;
            else if (ret_en && sp_reg == '0)        op = OP_UNDER;
            else if (ret_en)                        op = OP_RET;
            else if (call_en && sp_reg == SPW'(DEPTH)) op = OP_OVER;
            else if (call_en)                       op = OP_CALL;
            else if (jmp_en || (br_en && br_flag))  op = OP_JUMP;
            else                                    op = OP_NEXT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            sp_reg    <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sp_reg    <= sp_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    // Stack contents need no reset; sp alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push)
            stack[AW'(sp_reg)] <= curr_pc + D'(1);
    end

    always_comb begin
        state_next = state_reg;
        sp_next    = sp_reg;
        ovf_next   = ovf_reg;
        unf_next   = unf_reg;
        push       = 1'b0;
        if (state_reg == IDLE && start)
            state_next = RUN;
        case (op)
            OP_HALT:  state_next = HALT;
            OP_UNDER: begin
                unf_next   = 1'b1;
                state_next = HALT;
            end
            OP_RET:   sp_next = sp_reg - SPW'(1);
            OP_OVER:  begin
                ovf_next   = 1'b1;
                state_next = HALT;
            end
            OP_CALL:  begin
                push    = !reset;
                sp_next = sp_reg + SPW'(1);
            end
            default:  ;
        endcase
    end

    always_comb begin
        pc_absjump = 1'b1;
        pc_target  = curr_pc;
        case (op)
            OP_RET:  pc_target = ret_addr;
            OP_CALL, OP_JUMP: pc_target = target;
            OP_NEXT: begin
                pc_absjump = 1'b0;
                pc_target  = target;
            end
            default: ;
        endcase
        if (reset) begin
            pc_absjump = 1'b0;
            pc_target  = '0;
        end
    end

    assign running       = (state_reg == RUN);
    assign halted        = (state_reg == HALT);
    assign err_overflow  = ovf_reg;
    assign err_underflow = unf_reg;
    assign sp            = sp_reg;
endmodule
